// File: rtl/fetch_queue.sv
// Four-entry instruction fetch queue between the PC/IMEM stage and decode.
// A taken-branch flush keeps only the delay-slot instruction.
module fetch_queue #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] PC_BASE = 32'h00003000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Pc_In,
    input  logic [31:0] Instr_In,
    input  logic        Fetch_Valid_In,
    input  logic        Dec_Ready_In,
    input  logic        Flush_In,
    output logic [31:0] Instr_Out,
    output logic [31:0] Pc_Out,
    output logic [31:0] Pc8_Out,
    output logic        Valid_Out,
    output logic        Pause_Out,
    output logic [2:0]  Count_Out,
    output logic        Err_Out
);

    localparam logic [2:0] FULL = 3'(DEPTH);

    logic [31:0] instr_q [DEPTH];
    logic [31:0] pc_q    [DEPTH];

    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q,  count_d;
    logic        err_q,    err_d;

    logic        valid;
    logic        pause;
    logic        pop;
    logic        push;
    logic [31:0] pc_byte;
    logic [2:0]  remain;
    logic [1:0]  cand_ptr;

    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [31:0] wr_instr;
    logic [31:0] wr_pc;

    assign valid   = (count_q != 3'd0);
    assign pause   = (count_q == FULL);
    assign pop     = Dec_Ready_In & valid;
    assign push    = Fetch_Valid_In & ~pause & ~Flush_In;
    assign pc_byte = (Pc_In << 2) + PC_BASE;

    // Entries left after the branch (head) is consumed; the oldest one is the delay slot.
    assign remain   = count_q - {2'b00, pop};
    assign cand_ptr = rd_ptr_q + {1'b0, pop};

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = wr_ptr_q;
        wr_instr = Instr_In;
        wr_pc    = pc_byte;

        if (Flush_In) begin
            rd_ptr_d = 2'd0;
            if (remain != 3'd0) begin
                wr_en    = 1'b1;
                wr_idx   = 2'd0;
                wr_instr = instr_q[cand_ptr];
                wr_pc    = pc_q[cand_ptr];
                wr_ptr_d = 2'd1;
                count_d  = 3'd1;
            end else if (Fetch_Valid_In) begin
                wr_en    = 1'b1;
                wr_idx   = 2'd0;
                wr_ptr_d = 2'd1;
                count_d  = 3'd1;
            end else begin
                wr_ptr_d = 2'd0;
                count_d  = 3'd0;
                err_d    = 1'b1;
            end
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage is never reset; the empty-queue output masking hides stale contents.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            instr_q[wr_idx] <= wr_instr;
            pc_q[wr_idx]    <= wr_pc;
        end
    end

    assign Instr_Out = valid ? instr_q[rd_ptr_q] : 32'd0;
    assign Pc_Out    = valid ? pc_q[rd_ptr_q] : 32'd0;
    assign Pc8_Out   = valid ? (pc_q[rd_ptr_q] + 32'd8) : 32'd0;
    assign Valid_Out = valid;
    assign Pause_Out = pause;
    assign Count_Out = count_q;
    assign Err_Out   = err_q;

endmodule
